// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// master: the bridge itself; slave: the requester plus the muxed APB slave side.
interface apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] mst_prdata;
  logic        mst_pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, mst_prdata, mst_pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, mst_prdata, mst_pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding command-to-APB bridge for four slaves in 4 KiB windows,
// with address decode errors and an optional ACCESS wait-state timeout.
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  apb_master_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      paddr_q;
  logic [31:0]      pwdata_q;
  logic             pwrite_q;
  logic [3:0]       psel_q;
  logic             penable_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;

  logic             addr_ok;
  logic [3:0]       sel_dec;
  logic             timeout_hit;

  assign addr_ok     = (bus.cmd_addr[31:14] == 18'd0);
  assign sel_dec     = 4'b0001 << bus.cmd_addr[13:12];
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // Response fields are a one-cycle pulse and read as zero otherwise.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (addr_ok) begin
              paddr_q   <= bus.cmd_addr;
              pwdata_q  <= bus.cmd_wdata;
              pwrite_q  <= bus.cmd_write;
              psel_q    <= sel_dec;
              penable_q <= 1'b0;
              state     <= SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // Ready takes priority over a timeout reached in the same cycle.
          if (bus.mst_pready) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state       <= IDLE;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? 32'd0 : bus.mst_prdata;
          end else if (timeout_hit) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state       <= IDLE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          psel_q    <= '0;
          penable_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a transaction-level model predicts every output each
// cycle from the command, its wait count and the decode/timeout rules.
module tb_apb_master;
  localparam int TO = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;

  apb_master_if bus();

  apb_master #(.TIMEOUT(TO)) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus.master)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic        e_ready, e_pen, e_pwrite, e_rv, e_err;
  logic [3:0]  e_psel;
  logic [31:0] e_paddr, e_pwdata, e_rdata;

  // Model of the held APB address phase
  logic [31:0] m_paddr = 32'd0;
  logic [31:0] m_pwdata = 32'd0;
  logic        m_pwrite = 1'b0;

  // Observation records for hand-computed checks
  int          psel_cycles = 0;
  int          pen_cycles = 0;
  int          rsp_count = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  logic [3:0]  last_psel = 4'd0;
  logic [3:0]  psel_hist[$];

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
      chk("psel",      32'(bus.psel),      32'(e_psel));
      chk("penable",   32'(bus.penable),   32'(e_pen));
      chk("paddr",     bus.paddr,          e_paddr);
      chk("pwrite",    32'(bus.pwrite),    32'(e_pwrite));
      chk("pwdata",    bus.pwdata,         e_pwdata);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      chk("rsp_err",   32'(bus.rsp_err),   32'(e_err));
      chk("rsp_rdata", bus.rsp_rdata,      e_rdata);
      chk("psel_onehot0", 32'($onehot0(bus.psel)), 32'd1);
      chk("penable_wo_psel", 32'(bus.penable && (bus.psel == 4'd0)), 32'd0);
      if (bus.psel != 4'd0) begin
        psel_cycles++;
        last_psel = bus.psel;
      end
      if (bus.penable) pen_cycles++;
      if (bus.rsp_valid) begin
        rsp_count++;
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
      end
      psel_hist.push_back(bus.psel);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_idle(input logic rv, input logic er, input logic [31:0] rd);
    e_ready  = 1'b1;
    e_psel   = 4'd0;
    e_pen    = 1'b0;
    e_paddr  = m_paddr;
    e_pwrite = m_pwrite;
    e_pwdata = m_pwdata;
    e_rv     = rv;
    e_err    = er;
    e_rdata  = rd;
  endtask

  task automatic noise();
    bus.mst_pready = 1'($urandom_range(0, 1));
    bus.mst_prdata = $urandom;
  endtask

  task automatic idle_cmd();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
  endtask

  // Requests while busy must be ignored.
  task automatic busy_cmd();
    idle_cmd();
    bus.cmd_valid = 1'($urandom_range(0, 1));
  endtask

  // Called inside an IDLE cycle whose expectation is already set; returns in
  // the response cycle with its expectation set. abort asserts reset in the
  // second ACCESS cycle and returns in the first idle cycle after release.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] prd, input bit abort);
    bit          tmo;
    int          n;
    logic [31:0] rd;
    rd = 32'd0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    noise();
    step();
    if (addr[31:14] != 18'd0) begin
      idle_cmd();
      noise();
      set_idle(1'b1, 1'b1, 32'd0);
      return;
    end
    busy_cmd();
    noise();
    m_paddr  = addr;
    m_pwrite = wr;
    m_pwdata = wd;
    e_ready  = 1'b0;
    e_psel   = 4'b0001 << addr[13:12];
    e_pen    = 1'b0;
    e_paddr  = addr;
    e_pwrite = wr;
    e_pwdata = wd;
    e_rv     = 1'b0;
    e_err    = 1'b0;
    e_rdata  = 32'd0;
    tmo = (TO > 0) && (waits >= TO);
    n   = tmo ? TO : waits + 1;
    for (int i = 0; i < n; i++) begin
      step();
      busy_cmd();
      e_pen = 1'b1;
      bus.mst_pready = (!tmo && (i == n - 1));
      bus.mst_prdata = bus.mst_pready ? prd : $urandom;
      if (bus.mst_pready) rd = prd;
      if (abort && i == 1) begin
        bus.mst_pready = 1'b0;
        bus.cmd_valid  = 1'b0;
        #2;
        chk_en  = 1'b0;
        presetn = 1'b0;
        #1;
        chk("arst_psel",      32'(bus.psel),      32'd0);
        chk("arst_penable",   32'(bus.penable),   32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_paddr",     bus.paddr,          32'd0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge pclk);
        #4;
        presetn = 1'b1;
        step();
        m_paddr  = 32'd0;
        m_pwdata = 32'd0;
        m_pwrite = 1'b0;
        idle_cmd();
        noise();
        set_idle(1'b0, 1'b0, 32'd0);
        chk_en = 1'b1;
        return;
      end
    end
    step();
    idle_cmd();
    noise();
    set_idle(1'b1, tmo, (!wr && !tmo) ? rd : 32'd0);
  endtask

  task automatic idle_cycle();
    step();
    idle_cmd();
    noise();
    set_idle(1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    int          waits, gaps, rc;
    logic [17:0] hi;
    logic [31:0] addr;
    logic [3:0]  exp_hist [7];
    exp_hist = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};

    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = 32'd0;
    bus.cmd_wdata  = 32'd0;
    bus.mst_pready = 1'b0;
    bus.mst_prdata = 32'd0;
    #2;
    chk("rst_paddr",     bus.paddr,          32'd0);
    chk("rst_pwdata",    bus.pwdata,         32'd0);
    chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
    chk("rst_psel",      32'(bus.psel),      32'd0);
    chk("rst_penable",   32'(bus.penable),   32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    #10;
    presetn = 1'b1;
    step();
    set_idle(1'b0, 1'b0, 32'd0);
    chk_en = 1'b1;

    // Zero-wait read from slave 2
    psel_cycles = 0; rsp_count = 0;
    do_txn(1'b0, 32'h0000_2004, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
    idle_cycle();
    chk("r22_rdata",       last_rdata,          32'hDEAD_BEEF);
    chk("r22_err",         32'(last_err),       32'd0);
    chk("r22_psel_cycles", 32'(psel_cycles),    32'd2);
    chk("r22_psel",        32'(last_psel),      32'b0100);
    chk("r22_rsp_count",   32'(rsp_count),      32'd1);

    // Write to slave 3 with three wait states
    psel_cycles = 0; pen_cycles = 0; rsp_count = 0;
    do_txn(1'b1, 32'h0000_3010, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0);
    idle_cycle();
    chk("w23_psel_cycles", 32'(psel_cycles), 32'd5);
    chk("w23_pen_cycles",  32'(pen_cycles),  32'd4);
    chk("w23_psel",        32'(last_psel),   32'b1000);
    chk("w23_rdata",       last_rdata,       32'd0);
    chk("w23_rsp_count",   32'(rsp_count),   32'd1);

    // Decode error
    psel_cycles = 0; rsp_count = 0;
    do_txn(1'b0, 32'h0001_0000, 32'd0, 0, 32'd0, 1'b0);
    idle_cycle();
    chk("d24_psel_cycles", 32'(psel_cycles), 32'd0);
    chk("d24_err",         32'(last_err),    32'd1);
    chk("d24_rsp_count",   32'(rsp_count),   32'd1);

    // Timeout, then an immediately following command
    pen_cycles = 0; rsp_count = 0;
    do_txn(1'b0, 32'h0000_0100, 32'd0, TO, 32'd0, 1'b0);
    idle_cycle();
    chk("t25_pen_cycles", 32'(pen_cycles), 32'd16);
    chk("t25_err",        32'(last_err),   32'd1);
    chk("t25_rdata",      last_rdata,      32'd0);
    do_txn(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 0, 32'd0, 1'b0);
    idle_cycle();
    chk("t25_next_err",   32'(last_err),   32'd0);
    chk("t25_rsp_count",  32'(rsp_count),  32'd2);

    // Back-to-back reads to slaves 0 and 1
    psel_hist.delete();
    do_txn(1'b0, 32'h0000_0010, 32'd0, 0, 32'h1111_0000, 1'b0);
    do_txn(1'b0, 32'h0000_1020, 32'd0, 0, 32'h2222_0000, 1'b0);
    idle_cycle();
    chk("b26_hist_len", 32'(psel_hist.size() >= 7), 32'd1);
    if (psel_hist.size() >= 7)
      for (int i = 1; i < 7; i++) chk("b26_psel_seq", 32'(psel_hist[i]), 32'(exp_hist[i]));
    chk("b26_rdata", last_rdata, 32'h2222_0000);

    // Reset during ACCESS, then a normal read
    rc = rsp_count;
    do_txn(1'b0, 32'h0000_2000, 32'd0, 10, 32'd0, 1'b1);
    idle_cycle();
    chk("r27_no_rsp", 32'(rsp_count), 32'(rc));
    do_txn(1'b0, 32'h0000_0040, 32'd0, 1, 32'hCAFE_F00D, 1'b0);
    idle_cycle();
    chk("r27_rdata",     last_rdata,      32'hCAFE_F00D);
    chk("r27_rsp_count", 32'(rsp_count),  32'(rc + 1));

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 5);
      addr  = {18'd0, 14'($urandom)};
      if ($urandom_range(0, 5) == 0) begin
        hi   = 18'($urandom_range(1, 262143));
        addr = {hi, addr[13:0]};
      end
      do_txn(1'($urandom_range(0, 1)), addr, $urandom, waits, $urandom, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        gaps = $urandom_range(1, 3);
        for (int g = 0; g < gaps; g++) idle_cycle();
      end
    end
    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
